// File: rtl/iob_plic_pkg.sv
// Shared PLIC definitions: source count, target address map and the
// claimer state encoding.
package iob_plic_pkg;

   localparam int PLIC_N_SRC      = 63;
   localparam int PLIC_ID_W       = $clog2(PLIC_N_SRC + 1);

   localparam int PLIC_CTX_BASE   = 'h0000;
   localparam int PLIC_CTX_STRIDE = 'h0010;
   localparam int PLIC_CLAIM_OFF  = 'h0000;

   // Byte address of the claim/complete register of one target.
   function automatic int plic_claim_addr(input int tgt);
      return PLIC_CTX_BASE + tgt * PLIC_CTX_STRIDE + PLIC_CLAIM_OFF;
   endfunction

   localparam int PLIC_CLAIM_ADDR = plic_claim_addr(0);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RD_REQ  = 3'd1,
      ST_RD_WAIT = 3'd2,
      ST_PRESENT = 3'd3,
      ST_SERVICE = 3'd4,
      ST_WR_REQ  = 3'd5
   } claim_st_t;

   localparam logic [7:0] SPUR_MAX = 8'hFF;

endpackage

// File: rtl/iob_plic_claimer.sv
// PLIC target claimer: reads the claim register over IOb, hands the ID to
// the CPU, and writes it back as completion once the handler is done.
module iob_plic_claimer
   import iob_plic_pkg::*;
#(
   parameter int ADDR_W     = 16,
   parameter int DATA_W     = 32,
   parameter int ID_W       = PLIC_ID_W,
   parameter int CLAIM_ADDR = PLIC_CLAIM_ADDR
) (
   input  logic                clk_i,
   input  logic                arst_n_i,
   input  logic                irq_i,
   output logic                iob_avalid_o,
   output logic [ADDR_W-1:0]   iob_addr_o,
   output logic [DATA_W-1:0]   iob_wdata_o,
   output logic [DATA_W/8-1:0] iob_wstrb_o,
   input  logic                iob_ready_i,
   input  logic                iob_rvalid_i,
   input  logic [DATA_W-1:0]   iob_rdata_i,
   output logic                id_valid_o,
   output logic [ID_W-1:0]     id_o,
   input  logic                id_ready_i,
   input  logic                done_i,
   output logic                busy_o,
   output logic [7:0]          spurious_o
);

   localparam logic [ADDR_W-1:0] LP_ADDR = ADDR_W'(CLAIM_ADDR);

   claim_st_t         r_state;
   claim_st_t         w_state_nxt;
   logic [ID_W-1:0]   r_id;
   logic [7:0]        r_spur;
   logic              w_avalid;
   logic              w_wr;
   logic              w_cap;
   logic              w_zero;
   logic [ID_W-1:0]   w_rd_id;
   logic              w_rd_unused;

   assign w_rd_id     = iob_rdata_i[ID_W-1:0];
   assign w_rd_unused = ^(iob_rdata_i >> ID_W);
   assign w_zero      = (w_rd_id == '0);

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_avalid    = 1'b0;
      w_wr        = 1'b0;
      w_cap       = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (irq_i) w_state_nxt = ST_RD_REQ;
         end
         ST_RD_REQ: begin
            w_avalid = 1'b1;
            if (iob_ready_i) w_state_nxt = ST_RD_WAIT;
         end
         ST_RD_WAIT: begin
            if (iob_rvalid_i) begin
               w_cap       = 1'b1;
               w_state_nxt = w_zero ? ST_IDLE : ST_PRESENT;
            end
         end
         ST_PRESENT: begin
            if (id_ready_i) w_state_nxt = ST_SERVICE;
         end
         ST_SERVICE: begin
            if (done_i) w_state_nxt = ST_WR_REQ;
         end
         ST_WR_REQ: begin
            w_avalid = 1'b1;
            w_wr     = 1'b1;
            if (iob_ready_i) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // ID is captured on every read response, zero included, so id_o
   // always shows the last claim result.
   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         r_id   <= '0;
         r_spur <= '0;
      end else if (w_cap) begin
         r_id <= w_rd_id;
         if (w_zero && (r_spur != SPUR_MAX)) begin
            r_spur <= r_spur + 8'd1;
         end
      end
   end

   assign iob_avalid_o = w_avalid;
   assign iob_addr_o   = w_avalid ? LP_ADDR : '0;
   assign iob_wdata_o  = w_wr ? DATA_W'(r_id) : '0;
   assign iob_wstrb_o  = w_wr ? '1 : '0;
   assign id_valid_o   = (r_state == ST_PRESENT);
   assign id_o         = r_id;
   assign busy_o       = (r_state != ST_IDLE);
   assign spurious_o   = r_spur;

endmodule

// File: tb/tb_iob_plic_claimer.sv
// Bench for iob_plic_claimer: IOb slave model, claim-lifecycle scoreboard,
// directed latency/reset/spurious cases and a randomized soak.
module tb_iob_plic_claimer;

   localparam int AW = 16;
   localparam int DW = 32;
   localparam int IW = 6;
   localparam logic [AW-1:0] CA = 16'h0124;

   logic          clk = 1'b0;
   logic          arst_n_i;
   logic          irq_i;
   logic          iob_avalid_o;
   logic [AW-1:0] iob_addr_o;
   logic [DW-1:0] iob_wdata_o;
   logic [3:0]    iob_wstrb_o;
   logic          iob_ready_i;
   logic          iob_rvalid_i;
   logic [DW-1:0] iob_rdata_i;
   logic          id_valid_o;
   logic [IW-1:0] id_o;
   logic          id_ready_i;
   logic          done_i;
   logic          busy_o;
   logic [7:0]    spurious_o;

   iob_plic_claimer #(
      .ADDR_W(AW), .DATA_W(DW), .ID_W(IW), .CLAIM_ADDR('h124)
   ) dut (
      .clk_i(clk), .arst_n_i(arst_n_i), .irq_i(irq_i),
      .iob_avalid_o(iob_avalid_o), .iob_addr_o(iob_addr_o),
      .iob_wdata_o(iob_wdata_o), .iob_wstrb_o(iob_wstrb_o),
      .iob_ready_i(iob_ready_i), .iob_rvalid_i(iob_rvalid_i),
      .iob_rdata_i(iob_rdata_i), .id_valid_o(id_valid_o), .id_o(id_o),
      .id_ready_i(id_ready_i), .done_i(done_i), .busy_o(busy_o),
      .spurious_o(spurious_o)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   int k_ready = 100;
   int k_lat   = 0;
   int k_id    = -1;
   bit k_stray = 0;
   bit k_rand  = 0;
   logic d_irq = 0, d_idr = 0, d_done = 0;

   bit            s_pend = 0;
   int            s_cnt  = 0;
   logic [IW-1:0] s_id   = '0;
   bit            s_resp = 0;

   task automatic step();
      @(posedge clk);
      #1;
      iob_rvalid_i = 1'b0;
      s_resp       = 1'b0;
      iob_rdata_i  = $urandom;
      if (s_pend) begin
         if (s_cnt == 0) begin
            iob_rvalid_i          = 1'b1;
            iob_rdata_i[IW-1:0]   = s_id;
            s_resp                = 1'b1;
            s_pend                = 1'b0;
         end else begin
            s_cnt--;
         end
      end else if (k_stray && $urandom_range(0, 9) == 0) begin
         iob_rvalid_i = 1'b1;
      end
      iob_ready_i = ($urandom_range(0, 99) < k_ready);
      if (k_rand) begin
         irq_i      = ($urandom_range(0, 99) < 40);
         id_ready_i = $urandom_range(0, 1) == 1;
         done_i     = ($urandom_range(0, 99) < 30);
      end else begin
         irq_i      = d_irq;
         id_ready_i = d_idr;
         done_i     = d_done;
      end
      if (iob_avalid_o && iob_ready_i && iob_wstrb_o == 4'h0) begin
         s_pend = 1'b1;
         s_cnt  = (k_lat < 0) ? $urandom_range(0, 3) : k_lat;
         if (k_id < 0)
            s_id = ($urandom_range(0, 3) == 0) ? '0 : IW'($urandom_range(1, 63));
         else
            s_id = IW'(k_id);
      end
   endtask

   // Scoreboard: abstract claim lifecycle
   int            m_spur = 0;
   bit            m_busy = 0;
   bit            m_svc  = 0;
   logic [IW-1:0] m_svc_id;
   logic [IW-1:0] exp_id_q[$];
   logic [IW-1:0] exp_wr_q[$];
   int            n_rd = 0, n_wr = 0;
   bit            p_ahold = 0, p_ihold = 0;
   logic [AW-1:0] p_addr;
   logic [3:0]    p_wstrb;
   logic [IW-1:0] p_id;

   always @(negedge clk) begin
      if (!arst_n_i) begin
         chk("rst_avalid", iob_avalid_o, 0);
         chk("rst_id_valid", id_valid_o, 0);
         chk("rst_busy", busy_o, 0);
         chk("rst_id", id_o, 0);
         chk("rst_spurious", spurious_o, 0);
         m_spur = 0; m_busy = 0; m_svc = 0;
         exp_id_q.delete(); exp_wr_q.delete();
         p_ahold = 0; p_ihold = 0;
      end else begin
         chk("spurious", spurious_o, m_spur);
         if (p_ahold) begin
            chk("avalid_hold", iob_avalid_o, 1);
            chk("addr_hold", iob_addr_o, p_addr);
            chk("wstrb_hold", iob_wstrb_o, p_wstrb);
         end
         if (p_ihold) begin
            chk("idv_hold", id_valid_o, 1);
            chk("id_hold", id_o, p_id);
         end
         if (iob_avalid_o) chk("addr", iob_addr_o, CA);
         if (iob_wstrb_o == 4'h0) chk("wdata_idle", iob_wdata_o, 0);
         if (!iob_avalid_o) chk("wstrb_idle", iob_wstrb_o, 0);
         if (m_busy) chk("busy", busy_o, 1);
         if (id_valid_o) chk("idv_expected", exp_id_q.size() > 0, 1);
         if (iob_avalid_o && iob_ready_i) begin
            if (iob_wstrb_o == 4'h0) begin
               chk("rd_while_busy", m_busy, 0);
               m_busy = 1;
               n_rd++;
            end else begin
               chk("wstrb", iob_wstrb_o, 4'hF);
               n_wr++;
               if (exp_wr_q.size() == 0)
                  chk("wr_unexpected", exp_wr_q.size(), 1);
               else
                  chk("wdata", iob_wdata_o, exp_wr_q.pop_front());
               m_busy = 0;
            end
         end
         if (s_resp) begin
            if (iob_rdata_i[IW-1:0] == '0) begin
               if (m_spur < 255) m_spur++;
               m_busy = 0;
            end else begin
               exp_id_q.push_back(iob_rdata_i[IW-1:0]);
            end
         end
         if (m_svc && done_i) begin
            exp_wr_q.push_back(m_svc_id);
            m_svc = 0;
         end
         if (id_valid_o && id_ready_i && exp_id_q.size() > 0) begin
            m_svc_id = exp_id_q.pop_front();
            chk("id", id_o, m_svc_id);
            m_svc = 1;
         end
         p_ahold = iob_avalid_o && !iob_ready_i;
         p_addr  = iob_addr_o;
         p_wstrb = iob_wstrb_o;
         p_ihold = id_valid_o && !id_ready_i;
         p_id    = id_o;
      end
   end

   task automatic drain();
      d_irq = 0; d_idr = 1; d_done = 1; k_ready = 100;
      for (int i = 0; i < 40; i++) begin
         step();
         if (!busy_o) break;
      end
      chk("drain_idle", busy_o, 0);
      d_idr = 0; d_done = 0;
   endtask

   task automatic async_reset();
      #2;
      arst_n_i = 1'b0;
      #1;
      chk("arst_avalid", iob_avalid_o, 0);
      chk("arst_id_valid", id_valid_o, 0);
      chk("arst_busy", busy_o, 0);
      chk("arst_id", id_o, 0);
      s_pend = 0;
      @(negedge clk);
      #1;
      arst_n_i = 1'b1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   int rd0, wr0;

   initial begin
      arst_n_i = 0; irq_i = 0; iob_ready_i = 0; iob_rvalid_i = 0;
      iob_rdata_i = '0; id_ready_i = 0; done_i = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_busy", busy_o, 0);
      chk("reset_avalid", iob_avalid_o, 0);
      @(negedge clk);
      #1;
      arst_n_i = 1;

      // zero-wait claim of ID 5
      k_ready = 100; k_lat = 0; k_id = 5;
      d_irq = 1; step();
      d_irq = 0; step();
      chk("lat_avalid", iob_avalid_o, 1);
      chk("lat_rd_wstrb", iob_wstrb_o, 0);
      chk("lat_rd_addr", iob_addr_o, CA);
      step();
      chk("lat_wait_avalid", iob_avalid_o, 0);
      chk("lat_wait_idv", id_valid_o, 0);
      d_idr = 1; step();
      chk("lat_idv", id_valid_o, 1);
      chk("lat_id", id_o, 5);
      d_idr = 0; d_done = 1; step();
      chk("svc_idv", id_valid_o, 0);
      chk("svc_busy", busy_o, 1);
      d_done = 0; step();
      chk("wr_avalid", iob_avalid_o, 1);
      chk("wr_wstrb", iob_wstrb_o, 4'hF);
      chk("wr_wdata", iob_wdata_o, 5);
      step();
      chk("wr_done_idle", busy_o, 0);

      // slave stalls the read for 4 cycles
      rd0 = n_rd; k_id = 9; k_ready = 0;
      d_irq = 1; step();
      d_irq = 0;
      repeat (4) begin
         step();
         chk("stall_avalid", iob_avalid_o, 1);
      end
      k_ready = 100;
      drain();
      chk("stall_one_read", n_rd - rd0, 1);

      // spurious claims and saturation
      k_id = 0;
      d_irq = 1; step(); step(); step(); step();
      chk("spur_first", spurious_o, 1);
      repeat (1000) step();
      chk("spur_sat", spurious_o, 255);
      drain();

      // done in PRESENT and irq in SERVICE are ignored
      k_id = 12; rd0 = n_rd; wr0 = n_wr;
      d_irq = 1; step();
      d_irq = 0; step(); step();
      d_done = 1; step();
      d_done = 0; d_idr = 1; step();
      chk("done_in_present", id_valid_o, 1);
      d_idr = 0;
      for (int i = 0; i < 6; i++) begin
         d_irq = i[0];
         step();
         chk("svc_no_req", iob_avalid_o, 0);
      end
      chk("svc_no_write", n_wr - wr0, 0);
      d_irq = 0; d_done = 1; step();
      d_done = 0; d_irq = 1; step();
      chk("wr12_avalid", iob_avalid_o, 1);
      chk("wr12_wdata", iob_wdata_o, 12);
      step();
      chk("wr12_idle", busy_o, 0);
      d_irq = 0; step();
      chk("irq_kept", iob_avalid_o, 1);
      drain();
      chk("two_reads", n_rd - rd0, 2);

      // reset mid RD_WAIT
      k_id = 20; k_lat = 5;
      d_irq = 1; step();
      d_irq = 0; step(); step();
      chk("rdwait_busy", busy_o, 1);
      async_reset();
      k_lat = 0;
      d_irq = 1; step();
      d_irq = 0; step();
      chk("fresh1_avalid", iob_avalid_o, 1);
      drain();

      // reset mid WR_REQ
      k_id = 33;
      d_irq = 1; step();
      d_irq = 0; step(); step();
      d_idr = 1; step();
      d_idr = 0; d_done = 1; k_ready = 0; step();
      d_done = 0; step();
      chk("wrreq_avalid", iob_avalid_o, 1);
      chk("wrreq_wdata", iob_wdata_o, 33);
      async_reset();
      k_ready = 100;
      d_irq = 1; step();
      d_irq = 0; step();
      chk("fresh2_avalid", iob_avalid_o, 1);
      drain();

      // randomized soak
      k_rand = 1; k_ready = 60; k_lat = -1; k_id = -1; k_stray = 1;
      repeat (3000) step();
      k_rand = 0; k_stray = 0;
      drain();
      chk("id_q_empty", exp_id_q.size(), 0);
      chk("wr_q_empty", exp_wr_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/iob_plic_claimer.md
IOB_PLIC_CLAIMER -- requirements
Module: iob_plic_claimer

Interface
REQ-001 SHALL have parameter ADDR_W, default 16: IOb address width.
REQ-002 SHALL have parameter DATA_W, default 32: IOb data width.
REQ-003 SHALL have parameter ID_W, default 6: interrupt ID width; ID_W<=DATA_W.
REQ-004 SHALL have parameter CLAIM_ADDR, default 0: byte address of this target's claim/complete register.
REQ-005 SHALL have port clk_i, input, 1: the single system clock.
REQ-006 SHALL have port arst_n_i, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port irq_i, input, 1: interrupt request from the PLIC for this target.
REQ-008 SHALL have IOb master ports iob_avalid_o (1), iob_addr_o (ADDR_W), iob_wdata_o (DATA_W) and iob_wstrb_o (DATA_W/8), all outputs.
REQ-009 SHALL have IOb master ports iob_ready_i (1), iob_rvalid_i (1) and iob_rdata_i (DATA_W), all inputs.
REQ-010 SHALL have ports id_valid_o (output, 1), id_o (output, ID_W) and id_ready_i (input, 1): claimed-ID stream to the CPU.
REQ-011 SHALL have ports done_i (input, 1): CPU handler finished; and busy_o (output, 1): high in any non-IDLE state.
REQ-012 SHALL have port spurious_o, output, 8: saturating count of zero-ID claims.

Function
REQ-013 SHALL implement the states IDLE, RD_REQ, RD_WAIT, PRESENT, SERVICE and WR_REQ.
REQ-014 IDLE: irq_i=1 SHALL move the FSM to RD_REQ on the next edge; irq_i=0 SHALL keep it in IDLE.
REQ-015 RD_REQ: SHALL drive iob_avalid_o=1, iob_addr_o=CLAIM_ADDR and iob_wstrb_o=0.
REQ-016 RD_REQ: SHALL hold these outputs until iob_ready_i=1; the request is accepted on that edge and the FSM moves to RD_WAIT.
REQ-017 RD_WAIT: iob_avalid_o SHALL be 0; on iob_rvalid_i=1 the block SHALL latch iob_rdata_i[ID_W-1:0].
REQ-018 RD_WAIT: a nonzero latched ID SHALL move the FSM to PRESENT.
REQ-019 RD_WAIT: a zero latched ID SHALL increment spurious_o, saturating at 255, and return the FSM to IDLE.
REQ-020 PRESENT: SHALL hold id_valid_o=1 with id_o stable; id_valid_o & id_ready_i SHALL move the FSM to SERVICE.
REQ-021 id_ready_i SHALL be ignored outside PRESENT.
REQ-022 SERVICE: done_i=1 SHALL move the FSM to WR_REQ; done_i SHALL be ignored in every other state.
REQ-023 SERVICE: irq_i SHALL be ignored.
REQ-024 WR_REQ: SHALL drive iob_avalid_o=1, iob_addr_o=CLAIM_ADDR, iob_wdata_o=zero-extended latched ID and iob_wstrb_o all ones.
REQ-025 WR_REQ: SHALL hold until iob_ready_i=1, then move to IDLE; no iob_rvalid_i is expected for a write.
REQ-026 Claim latency with a zero-wait slave: irq_i rise at edge N SHALL give avalid in cycle N+1 and id_valid_o=1 in cycle N+3.
REQ-027 iob_rvalid_i outside RD_WAIT SHALL be ignored.
REQ-028 irq_i=1 on the edge that finishes WR_REQ SHALL NOT be lost: IDLE samples it on the following cycle.
REQ-029 iob_avalid_o SHALL be 0 in every state other than RD_REQ and WR_REQ.
REQ-030 iob_wdata_o and iob_wstrb_o SHALL be 0 outside WR_REQ.

Reset
REQ-031 arst_n_i=0 SHALL immediately (asynchronously) force state IDLE.
REQ-032 arst_n_i=0 SHALL immediately force iob_avalid_o, id_valid_o and busy_o to 0.
REQ-033 arst_n_i=0 SHALL immediately clear id_o and spurious_o to 0, abandoning any transfer in flight.
REQ-034 Reset release SHALL take effect synchronously on a clk_i edge; the first claim may start on the first edge after release.

Structure
REQ-035 The state encoding SHALL live in the shared iob_plic package; ID_W and CLAIM_ADDR SHALL be derived there from the existing PLIC source count and target address map.
REQ-036 The block SHALL be a single module with no sub-modules; the FSM, ID register and saturating counter are inline.

Verification
REQ-037 Zero-wait slave, read returns 5: irq_i=1 -> avalid with wstrb=0 at CLAIM_ADDR, then id_valid_o=1 with id_o=5 three cycles after irq_i; id_ready_i, then done_i -> one write of wdata=5, wstrb=4'hF.
REQ-038 Slave holds iob_ready_i=0 for 4 cycles in RD_REQ -> avalid and addr stay stable for those 4 cycles, with exactly one accepted request.
REQ-039 Read returns 0 -> spurious_o goes 0 to 1, FSM returns to IDLE, id_valid_o never asserts; 300 spurious claims -> spurious_o=255.
REQ-040 done_i pulsed in PRESENT and irq_i toggled in SERVICE -> no write and no new read; write occurs only after done_i in SERVICE.
REQ-041 arst_n_i=0 asserted mid RD_WAIT and again mid WR_REQ -> iob_avalid_o, id_valid_o and busy_o drop before the next edge; after release, irq_i=1 starts a fresh claim.
